ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//  Initiator side of the single-port nibble RAM bus (cs/we/address/shared bidirectional data).
//  Accepts read/write burst requests from the processor datapath and sequences them onto the RAM pins.
//  Drives the shared data bus only during write beats and inserts turnaround cycles.
//  Returns read nibbles with a valid strobe.
//  Sits between the processor core and the RAM instance.
// PARAMETERS
//  N         12    address width
//  M         4     data width (nibble)
//  L         4     burst-length field width; a burst is req_len+1 beats (1..2^L)
//  MEM_DEPTH 4001  implemented RAM words (addresses 0..MEM_DEPTH-1)
// PORTS
//  clk        in    1  single clock; all state updates on rising edge
//  reset_n    in    1  synchronous, active-low reset
//  req_valid  in    1  request present
//  req_ready  out   1  master can accept (high only in IDLE)
//  req_we     in    1  1=write burst, 0=read burst
//  req_addr   in    N  burst start address
//  req_len    in    L  beats minus one
//  wr_valid   in    1  write nibble available on wr_data
//  wr_data    in    M  write nibble
//  wr_ack     out   1  current wr_data consumed this cycle
//  rd_valid   out   1  rd_data holds a read nibble (one-cycle pulse per beat)
//  rd_data    out   M  read nibble
//  done       out   1  one-cycle pulse, burst complete
//  err        out   1  valid with done; start address out of range, no RAM access made
//  ram_cs     out   1  RAM chip select
//  ram_we     out   1  RAM write enable
//  ram_addr   out   N  RAM address
//  ram_data   inout M  shared data bus; driven only when ram_cs&&ram_we, else 'z
// BEHAVIOUR
//  Reset: state IDLE; ram_cs/ram_we/ram_addr/rd_valid/rd_data/done/err/wr_ack = 0; ram_data = 'z; last_dir = NONE.
//  Reset dominates mid-burst: the burst aborts, no done or further rd_valid, and cs drops at that edge.
//  States:
//   IDLE:  req_ready=1. A request is accepted when req_valid && req_ready.
//          addr >= MEM_DEPTH -> DONE with err=1.
//          Direction differs from last_dir (not NONE) -> TURN.
//          Otherwise -> READ or WRITE.
//   TURN:  exactly 1 cycle, ram_cs=0, bus released by both sides, then the op state.
//   READ:  each cycle is one beat (ram_cs=1, ram_we=0, ram_addr=beat address).
//          The RAM captures on the falling edge; the master samples ram_data at the next rising edge.
//          rd_valid/rd_data are registered 1 cycle after the beat.
//   WRITE: beat only when wr_valid=1. Then ram_cs=1, ram_we=1, ram_data=wr_data, and wr_ack=1 in the same cycle.
//          With wr_valid=0 the cycle is a stall: ram_cs=0, bus 'z, no count or address advance.
//          Address/data are set up at the rising edge and the RAM writes on the falling edge.
//  Beat counter loads req_len and decrements per beat; the last beat is at count 0.
//  Address increments per beat and wraps MEM_DEPTH-1 -> 0 (no error on wrap).
//  done pulses the cycle after the last beat. For reads this coincides with the last rd_valid.
//  Next state after the last beat is IDLE; a new request is accepted no earlier than the done cycle.
//  last_dir is updated at every burst end.
//  rd_data holds its value between pulses; no backpressure on reads.
// STRUCTURE
//  Package ram_bus_pkg:
//   state_t enum {IDLE,TURN,READ,WRITE,DONE}
//   dir_t {NONE,RD,WR}
//   MEM_DEPTH constant shared with the RAM instance
//  Sub-module ram_addr_seq: loadable address counter with MEM_DEPTH wrap plus beat down-counter; asserts last.
//  Top level: FSM, tri-state driver, read capture register.
// TESTING
//  1. Reset, write burst addr=5 len=3 data 1,2,3,4 (wr_valid held) -> 4 consecutive cs&we cycles, addr 5..8, done 1 cycle after.
//  2. Read burst addr=5 len=3 right after test 1 -> exactly 1 TURN cycle (cs=0), rd_data 1,2,3,4 on 4 consecutive rd_valid, done with last.
//  3. Write addr=3999 len=2 data A,B,C, then read back -> addresses 3999,4000,0 accessed, readback A,B,C.
//  4. Write len=3 with wr_valid low for 2 cycles mid-burst -> cs=0 and bus 'z during the stall, exactly 4 wr_ack, data intact on readback.
//  5. Request addr=4001 -> req accepted, no cs ever asserted, done=1 and err=1 same cycle.
//  6. Assert reset_n=0 during beat 2 of a 4-beat read -> cs=0 next edge, no done, no further rd_valid, req_ready=1 after release.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the nibble RAM bus master and the RAM it drives.
// Contents: bus geometry defaults, the master FSM state type and the
// bus-direction type used to decide when a turnaround cycle is needed.
package ram_bus_pkg;

   localparam int ADDR_W    = 12;    // address width
   localparam int DATA_W    = 4;     // nibble data width
   localparam int LEN_W     = 4;     // burst length field width (beats minus one)
   localparam int MEM_DEPTH = 4001;  // implemented RAM words, shared with the RAM instance

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TURN  = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } dir_t;

endpackage

// File: rtl/ram_bus_master_addr_seq.sv
// Burst address/beat sequencer for the RAM bus master.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   load              capture start_addr and len (burst accepted)
//   start_addr, len   burst start address and beats-minus-one
//   step              one beat completed this cycle: advance address, count down
//   addr              address of the current beat
//   last              current beat is the final one of the burst
module ram_addr_seq
   import ram_bus_pkg::*;
#(
   parameter int N     = ADDR_W,
   parameter int L     = LEN_W,
   parameter int DEPTH = MEM_DEPTH
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [N-1:0] start_addr,
   input  logic [L-1:0] len,
   input  logic         step,
   output logic [N-1:0] addr,
   output logic         last
);

   logic [N-1:0] addr_r;
   logic [L-1:0] cnt_r;
   logic [N-1:0] addr_inc_s;

   // Next sequential address; the top implemented word wraps back to 0.
   always_comb begin
      addr_inc_s = addr_r + {{(N-1){1'b0}}, 1'b1};
      if ({{(32-N){1'b0}}, addr_r} == 32'(DEPTH - 1)) begin
         addr_inc_s = {N{1'b0}};
      end else begin
         addr_inc_s = addr_r + {{(N-1){1'b0}}, 1'b1};
      end
   end

   // Address and remaining-beat registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_r <= {N{1'b0}};
         cnt_r  <= {L{1'b0}};
      end else if (load) begin
         addr_r <= start_addr;
         cnt_r  <= len;
      end else if (step) begin
         addr_r <= addr_inc_s;
         cnt_r  <= cnt_r - {{(L-1){1'b0}}, 1'b1};
      end else begin
         addr_r <= addr_r;
         cnt_r  <= cnt_r;
      end
   end

   assign addr = addr_r;
   assign last = (cnt_r == {L{1'b0}});

endmodule

// File: rtl/ram_bus_master.sv
// Initiator for the single-port nibble RAM bus. Accepts read/write burst
// requests, sequences them onto cs/we/addr and the shared data bus, inserts a
// one-cycle turnaround whenever the bus direction flips, and returns read
// nibbles with a valid strobe.
// Ports:
//   clk, reset_n                         clock, synchronous active-low reset
//   req_valid/req_ready/req_we/req_addr/req_len   burst request handshake
//   wr_valid/wr_data/wr_ack              write nibble stream (ack = consumed)
//   rd_valid/rd_data                     read nibble return, one pulse per beat
//   done/err                             burst completion, err = bad start address
//   ram_cs/ram_we/ram_addr/ram_data      RAM pins; ram_data is bidirectional
module ram_bus_master
   import ram_bus_pkg::*;
#(
   parameter int N     = ADDR_W,
   parameter int M     = DATA_W,
   parameter int L     = LEN_W,
   parameter int DEPTH = MEM_DEPTH
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [N-1:0] req_addr,
   input  logic [L-1:0] req_len,
   input  logic         wr_valid,
   input  logic [M-1:0] wr_data,
   output logic         wr_ack,
   output logic         rd_valid,
   output logic [M-1:0] rd_data,
   output logic         done,
   output logic         err,
   output logic         ram_cs,
   output logic         ram_we,
   output logic [N-1:0] ram_addr,
   inout  logic [M-1:0] ram_data
);

   state_t       state_r, state_s;
   dir_t         last_dir_r;
   dir_t         req_dir_s;
   logic         op_we_r;
   logic         rd_valid_r, done_r, err_r;
   logic [M-1:0] rd_data_r;

   logic         load_s, step_s, cs_s, we_s, ack_s, ready_s;
   logic         beat_last_s, err_accept_s;
   logic         range_err_s, turn_s;
   logic [N-1:0] seq_addr_s;
   logic         seq_last_s;

   ram_addr_seq #(
      .N     (N),
      .L     (L),
      .DEPTH (DEPTH)
   ) u_seq (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load_s),
      .start_addr (req_addr),
      .len        (req_len),
      .step       (step_s),
      .addr       (seq_addr_s),
      .last       (seq_last_s)
   );

   assign req_dir_s   = req_we ? WR : RD;
   assign range_err_s = ({{(32-N){1'b0}}, req_addr} >= 32'(DEPTH));
   // A turnaround is only needed when the bus has been used in the other direction.
   assign turn_s      = (last_dir_r != NONE) && (last_dir_r != req_dir_s);

   // Next-state and pin control. Write beats are gated directly by wr_valid so
   // that a stalled cycle leaves the RAM deselected and the bus released.
   always_comb begin
      state_s      = state_r;
      ready_s      = 1'b0;
      load_s       = 1'b0;
      step_s       = 1'b0;
      cs_s         = 1'b0;
      we_s         = 1'b0;
      ack_s        = 1'b0;
      beat_last_s  = 1'b0;
      err_accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            ready_s = 1'b1;
            if (req_valid) begin
               load_s = 1'b1;
               if (range_err_s) begin
                  err_accept_s = 1'b1;
                  state_s      = DONE;
               end else if (turn_s) begin
                  state_s = TURN;
               end else if (req_we) begin
                  state_s = WRITE;
               end else begin
                  state_s = READ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         TURN: begin
            state_s = op_we_r ? WRITE : READ;
         end
         READ: begin
            cs_s   = 1'b1;
            step_s = 1'b1;
            if (seq_last_s) begin
               beat_last_s = 1'b1;
               state_s     = IDLE;
            end else begin
               state_s = READ;
            end
         end
         WRITE: begin
            if (wr_valid) begin
               cs_s   = 1'b1;
               we_s   = 1'b1;
               ack_s  = 1'b1;
               step_s = 1'b1;
               if (seq_last_s) begin
                  beat_last_s = 1'b1;
                  state_s     = IDLE;
               end else begin
                  state_s = WRITE;
               end
            end else begin
               state_s = WRITE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, completion flags, direction history and read capture.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         last_dir_r <= NONE;
         op_we_r    <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= {M{1'b0}};
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         // The RAM drives the beat's nibble after the falling edge; it is
         // stable here at the end of the beat.
         rd_valid_r <= (state_r == READ);
         if (state_r == READ) begin
            rd_data_r <= ram_data;
         end else begin
            rd_data_r <= rd_data_r;
         end
         done_r     <= beat_last_s || err_accept_s;
         err_r      <= err_accept_s;
         if (load_s) begin
            op_we_r <= req_we;
         end else begin
            op_we_r <= op_we_r;
         end
         if (beat_last_s) begin
            last_dir_r <= op_we_r ? WR : RD;
         end else if (err_accept_s) begin
            last_dir_r <= req_dir_s;
         end else begin
            last_dir_r <= last_dir_r;
         end
      end
   end

   assign req_ready = ready_s;
   assign wr_ack    = ack_s;
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_r;
   assign done      = done_r;
   assign err       = err_r;
   assign ram_cs    = cs_s;
   assign ram_we    = we_s;
   assign ram_addr  = cs_s ? seq_addr_s : {N{1'b0}};
   assign ram_data  = (cs_s && we_s) ? wr_data : {M{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master: a behavioural RAM on the pins, a
// word-array reference model, and a scoreboard monitor fed by the driver.
module tb_ram_bus_master;

   localparam int DEPTH = 4001;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_we, wr_valid;
   logic [11:0] req_addr;
   logic [3:0]  req_len, wr_data;
   logic        req_ready, wr_ack, rd_valid, done, err, ram_cs, ram_we;
   logic [3:0]  rd_data;
   logic [11:0] ram_addr;
   wire  [3:0]  ram_data;

   ram_bus_master dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid),
      .wr_data(wr_data), .wr_ack(wr_ack), .rd_valid(rd_valid), .rd_data(rd_data),
      .done(done), .err(err), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_data(ram_data)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] init_val(input int i);
      return 4'((i * 7 + (i >> 3)) & 15);
   endfunction

   // Behavioural RAM: acts on the falling edge, drives the bus during read beats.
   logic [3:0] ram_mem [0:DEPTH-1];
   logic [3:0] ram_q = 4'd0;
   bit         ram_filled = 1'b0;
   always @(negedge clk) begin
      if (!ram_filled) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
         ram_filled <= 1'b1;
      end else if (ram_cs) begin
         if (ram_we) ram_mem[ram_addr] <= ram_data;
         else        ram_q <= ram_mem[ram_addr];
      end
   end
   assign ram_data = (ram_cs && !ram_we) ? ram_q : 4'bzzzz;

   // Reference model and scoreboard queues.
   typedef struct { bit we; int addr; int data; } acc_t;
   typedef struct { bit is_err; bit rd; } done_t;
   logic [3:0] model [0:DEPTH-1];
   int         last_dir_m = 0;   // 0 none, 1 read, 2 write
   acc_t       exp_acc[$];
   int         exp_rd[$];
   done_t      exp_done[$];
   int         checks = 0;
   int         failures = 0;

   function automatic void chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
      end
   endfunction

   // Monitor: pops expectations whenever the DUT shows a bus beat, read data or done.
   acc_t  ma;
   done_t md;
   always @(negedge clk) begin
      if (ram_cs) begin
         chk("ram_access_expected", int'(exp_acc.size() > 0), 1);
         if (exp_acc.size() > 0) begin
            ma = exp_acc.pop_front();
            chk("acc_we", int'(ram_we), int'(ma.we));
            chk("acc_addr", int'(ram_addr), ma.addr);
            if (ma.we) chk("acc_wdata", int'(ram_data), ma.data);
         end
      end
      if (wr_ack) chk("wr_ack_is_write_beat", int'(ram_cs && ram_we), 1);
      if (rd_valid) begin
         chk("rd_valid_expected", int'(exp_rd.size() > 0), 1);
         if (exp_rd.size() > 0) chk("rd_data", int'(rd_data), exp_rd.pop_front());
      end
      if (done) begin
         chk("done_expected", int'(exp_done.size() > 0), 1);
         if (exp_done.size() > 0) begin
            md = exp_done.pop_front();
            chk("done_err", int'(err), int'(md.is_err));
            chk("done_with_last_rd", int'(rd_valid), int'(md.rd && !md.is_err));
         end
      end
   end

   // One burst: pushes expectations, issues the request, drives write data,
   // and checks cycle-level timing (turnaround, stalls, done latency, reset abort).
   task automatic burst(input bit we, input int addr, input int len, input int base,
                        input int stall_at, input int stall_n, input bit rst_mid);
      logic [3:0] d [0:15];
      int  a, beats, acks, j, sc, idx, dirv;
      bit  is_err, turn, fin, stall_now;
      is_err = (addr >= DEPTH);
      dirv   = we ? 2 : 1;
      turn   = !is_err && last_dir_m != 0 && last_dir_m != dirv;
      last_dir_m = dirv;
      a = addr;
      for (int i = 0; i <= len; i++) begin
         d[i] = (base >= 0) ? 4'(base + i) : 4'($urandom_range(0, 15));
         if (!is_err) begin
            if (!rst_mid || i < 2) exp_acc.push_back('{we, a, int'(we ? d[i] : model[a])});
            if (!we && (!rst_mid || i == 0)) exp_rd.push_back(int'(model[a]));
            if (we) model[a] = d[i];
            a = (a == DEPTH - 1) ? 0 : a + 1;
         end
      end
      if (!rst_mid) exp_done.push_back('{is_err, !we});

      @(negedge clk);
      idx = 0;
      while (!req_ready && idx < 20) begin @(negedge clk); idx++; end
      chk("req_ready_before_issue", int'(req_ready), 1);
      req_valid = 1'b1; req_we = we; req_addr = 12'(addr); req_len = 4'(len);
      @(posedge clk); #1;
      req_valid = 1'b0;

      beats = 0; acks = 0; j = 0; sc = 0; fin = 1'b0; idx = 1;
      while (!fin && idx <= 60) begin
         stall_now = we && j > 0 && j == stall_at && sc < stall_n;
         if (we && !is_err && j <= len && !stall_now) begin
            wr_valid = 1'b1; wr_data = d[j];
         end else begin
            wr_valid = 1'b0;
         end
         @(negedge clk);
         if (is_err) begin
            chk("err_no_cs", int'(ram_cs), 0);
            chk("err_done_next_cycle", int'(done), 1);
            chk("err_flag", int'(err), 1);
            fin = 1'b1;
         end else begin
            if (ram_cs) begin
               if (beats == 0) chk("first_beat_cycle", idx, 1 + int'(turn));
               beats++;
            end
            if (stall_now) begin
               chk("stall_cs_low", int'(ram_cs), 0);
               chk("stall_we_low", int'(ram_we), 0);
               sc++;
            end
            if (wr_ack) begin acks++; j++; end
            if (rst_mid && beats == 1) begin
               @(posedge clk); #1; reset_n = 1'b0;     // second beat is in progress
               @(negedge clk);
               @(posedge clk); #1;
               @(negedge clk);
               chk("reset_cs_dropped", int'(ram_cs), 0);
               chk("reset_no_rd_valid", int'(rd_valid), 0);
               chk("reset_no_done", int'(done), 0);
               @(posedge clk); #1; reset_n = 1'b1;
               @(negedge clk);
               chk("ready_after_reset", int'(req_ready), 1);
               chk("no_done_after_reset", int'(done), 0);
               chk("abort_acc_consumed", exp_acc.size(), 0);
               chk("abort_rd_consumed", exp_rd.size(), 0);
               last_dir_m = 0;
               fin = 1'b1;
            end else if (beats == len + 1) begin
               @(posedge clk); #1; wr_valid = 1'b0;
               @(negedge clk);
               chk("done_after_last_beat", int'(done), 1);
               if (we) chk("wr_ack_count", acks, len + 1);
               fin = 1'b1;
            end
         end
         if (!fin) begin @(posedge clk); #1; idx++; end
      end
      if (!fin) chk("burst_completed_in_budget", 0, 1);
      wr_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int we, addr, len, sel;
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 12'd0;
      req_len = 4'd0; wr_valid = 1'b0; wr_data = 4'd0;
      for (int i = 0; i < DEPTH; i++) model[i] = init_val(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_ram_cs", int'(ram_cs), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_wr_ack", int'(wr_ack), 0);
      @(posedge clk); #1; reset_n = 1'b1;

      burst(1'b1, 5, 3, 1, 0, 0, 1'b0);        // write 1,2,3,4 at 5..8
      burst(1'b0, 5, 3, -1, 0, 0, 1'b0);       // read back, one turnaround
      burst(1'b1, 3999, 2, 10, 0, 0, 1'b0);    // A,B,C across the wrap
      burst(1'b0, 3999, 2, -1, 0, 0, 1'b0);
      burst(1'b1, 100, 3, -1, 2, 2, 1'b0);     // two stall cycles mid-burst
      burst(1'b0, 100, 3, -1, 0, 0, 1'b0);
      burst(1'b1, 4001, 0, -1, 0, 0, 1'b0);    // first unimplemented address
      burst(1'b0, 4095, 5, -1, 0, 0, 1'b0);
      burst(1'b0, 200, 3, -1, 0, 0, 1'b1);     // reset during beat 2
      burst(1'b0, 200, 0, -1, 0, 0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         we  = int'($urandom_range(0, 1));
         len = int'($urandom_range(0, 15));
         sel = int'($urandom_range(0, 9));
         if (sel < 6)       addr = int'($urandom_range(0, DEPTH - 1));
         else if (sel < 9)  addr = int'($urandom_range(DEPTH - 16, DEPTH - 1));
         else               addr = int'($urandom_range(DEPTH, 4095));
         burst(we[0], addr, len, -1, int'($urandom_range(1, 15)),
               int'($urandom_range(0, 3)), 1'b0);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("final_acc_queue_empty", exp_acc.size(), 0);
      chk("final_rd_queue_empty", exp_rd.size(), 0);
      chk("final_done_queue_empty", exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
